wb_stage: RTL

Writeback stage of the RISC-V pipeline: holds the MEM/WB pipeline register and produces the register file's write port (`Write_reg`, `Write_data`, `WEN`). It selects the result source (ALU, load, PC+4), aligns and sign/zero-extends load data, and rejects misaligned loads. It also exports the in-flight writeback for ID-stage forwarding.

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_stage_load_align.sv | 62 ++++++
 rtl/wb_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback stage and the ID/EX decoder.
//   XLEN        : integer register width (32)
//   wb_sel_e    : result-source select codes (ALU, load, PC+4, reserved)
//   F3_*        : load funct3 codes
//   sext8/sext16: sign-extension helpers for sub-word loads
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
        return {{(XLEN-8){b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] h);
        return {{(XLEN-16){h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load data extraction for the writeback stage.
// Picks the byte/half lane out of the raw memory word, sign- or zero-extends
// according to funct3, and flags addresses that are not naturally aligned.
// Ports:
//   rdata      in  XLEN : raw data-memory word
//   funct3     in  3    : load type
//   addr_lo    in  2    : low address bits (byte lane)
//   ldata      out XLEN : extracted, extended load value
//   misaligned out 1    : access not naturally aligned for its size
// Codes outside the five load types extract as a full word and never flag
// misalignment.
// -----------------------------------------------------------------------------
module load_align
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] ldata,
    output logic            misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
    end

    // A half-word always sits in lane 0 or lane 1 of the word; addr_lo[0]
    // only matters for the misalignment check.
    assign half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ldata = rdata;
        case (funct3)
            F3_LB:   ldata = sext8(byte_v);
            F3_LH:   ldata = sext16(half_v);
            F3_LBU:  ldata = {{(XLEN-8){1'b0}}, byte_v};
            F3_LHU:  ldata = {{(XLEN-16){1'b0}}, half_v};
            default: ldata = rdata;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            F3_LW:         misaligned = (addr_lo != 2'd0);
            F3_LH, F3_LHU: misaligned = addr_lo[0];
            default:       misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage: MEM/WB pipeline register, result-source mux, register-file
// write port and ID-stage forwarding export.
// Optional feature macro: WB_RETIRE_CNT_EN adds a 64-bit retired-instruction
// counter (retire_cnt) with a synchronous clear (retire_clr).
// Ports:
//   Clk, rst_n      : clock (rising edge), async active-low reset
//   mem_valid       : MEM holds a valid instruction
//   mem_stall       : MEM stalled; a bubble enters WB
//   mem_rd          : destination register
//   mem_reg_write   : instruction writes rd
//   mem_wb_sel      : result source (0 ALU, 1 load, 2 PC+4, 3 as ALU)
//   mem_funct3      : load type
//   mem_alu_result  : ALU result / load byte address
//   mem_pc_plus4    : link value
//   mem_rdata       : raw data-memory word
//   Write_reg       : register-file write index (always rd_q)
//   Write_data      : register-file write data
//   WEN             : register-file write enable
//   fwd_valid       : Write_data is live for ID forwarding (== WEN)
//   misalign_err    : WB instruction is a misaligned load
//   retire_clr      : (WB_RETIRE_CNT_EN) synchronous counter clear
//   retire_cnt      : (WB_RETIRE_CNT_EN) retired instruction count
// All outputs depend only on registered state.
// -----------------------------------------------------------------------------
module wb_stage
    import wb_pkg::*;
#(
    parameter int WB_SEL_W = 2
)
(
    input  logic                Clk,
    input  logic                rst_n,
    input  logic                mem_valid,
    input  logic                mem_stall,
    input  logic [4:0]          mem_rd,
    input  logic                mem_reg_write,
    input  logic [WB_SEL_W-1:0] mem_wb_sel,
    input  logic [2:0]          mem_funct3,
    input  logic [XLEN-1:0]     mem_alu_result,
    input  logic [XLEN-1:0]     mem_pc_plus4,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [4:0]          Write_reg,
    output logic [XLEN-1:0]     Write_data,
    output logic                WEN,
    output logic                fwd_valid,
    output logic                misalign_err
`ifdef WB_RETIRE_CNT_EN
    ,
    input  logic                retire_clr,
    output logic [63:0]         retire_cnt
`endif
);

    logic                valid_q;
    logic [4:0]          rd_q;
    logic                regw_q;
    logic [WB_SEL_W-1:0] sel_q;
    logic [2:0]          f3_q;
    logic [1:0]          addr_lo_q;
    logic [XLEN-1:0]     alu_q;
    logic [XLEN-1:0]     pc4_q;
    logic [XLEN-1:0]     rdata_q;

    logic [XLEN-1:0]     ldata;
    logic                la_misaligned;
    logic                is_load;
    logic                misaligned;

    // A stall only kills valid_q; the remaining fields simply hold, which
    // keeps them quiet without extra enables.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rd_q      <= '0;
            regw_q    <= 1'b0;
            sel_q     <= '0;
            f3_q      <= '0;
            addr_lo_q <= '0;
            alu_q     <= '0;
            pc4_q     <= '0;
            rdata_q   <= '0;
        end else if (mem_stall) begin
            valid_q   <= 1'b0;
        end else begin
            valid_q   <= mem_valid;
            rd_q      <= mem_rd;
            regw_q    <= mem_reg_write;
            sel_q     <= mem_wb_sel;
            f3_q      <= mem_funct3;
            addr_lo_q <= mem_alu_result[1:0];
            alu_q     <= mem_alu_result;
            pc4_q     <= mem_pc_plus4;
            rdata_q   <= mem_rdata;
        end
    end

    load_align u_load_align (
        .rdata      (rdata_q),
        .funct3     (f3_q),
        .addr_lo    (addr_lo_q),
        .ldata      (ldata),
        .misaligned (la_misaligned)
    );

    assign is_load    = (sel_q == WB_SEL_W'(WB_LOAD));
    assign misaligned = is_load & la_misaligned;

    // Reserved select code falls through to the ALU result.
    always_comb begin
        Write_data = alu_q;
        if (is_load) begin
            Write_data = ldata;
        end else if (sel_q == WB_SEL_W'(WB_PC4)) begin
            Write_data = pc4_q;
        end
    end

    assign Write_reg    = rd_q;
    assign WEN          = valid_q & regw_q & (rd_q != 5'd0) & ~misaligned;
    assign fwd_valid    = WEN;
    assign misalign_err = valid_q & misaligned;

`ifdef WB_RETIRE_CNT_EN
    // Counts every instruction that completes, including ones that do not
    // write a register; misaligned loads trap and are not retired.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (retire_clr) begin
            retire_cnt <= '0;
        end else if (valid_q && !misaligned) begin
            retire_cnt <= retire_cnt + 64'd1;
        end
    end
`endif

endmodule
